// File: rtl/shift_deserializer_if.sv
// Handshake bundle between the serial source, the deserializer and the word consumer.
interface shift_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             d;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] Q;
    logic             valid;
    logic             busy;

    // Deserializer side.
    modport slave (
        input  d,
        input  start,
        input  ready,
        output Q,
        output valid,
        output busy
    );

    // Stimulus / consumer side.
    modport master (
        output d,
        output start,
        output ready,
        input  Q,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel stage: shifts WIDTH bits in MSB-first after a start,
// then holds the word with valid until the consumer accepts it.
module shift_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 c,
    input  logic                 rn,
    shift_deserializer_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] FULL  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;

    // State and output registers.
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state_q <= IDLE;
            q_q     <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    count_d = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                q_d = {q_q[WIDTH-2:0], bus.d};
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FULL;
                    count_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            FULL: begin
                // Accept with start asserted chains straight into the next word.
                if (bus.ready) begin
                    valid_d = 1'b0;
                    count_d = '0;
                    if (bus.start) begin
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.Q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer at WIDTH=4.
module tb_shift_deserializer;

    localparam int unsigned WIDTH = 4;

    logic c;
    logic rn;
    logic clk_en;
    int   tests;
    int   failed;

    shift_deserializer_if #(.WIDTH(WIDTH)) bus ();

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .c   (c),
        .rn  (rn),
        .bus (bus)
    );

    always begin
        #5;
        if (clk_en) c = ~c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] q_exp,
                           input logic v_exp, input logic b_exp);
        chk({tag, ".Q"},     32'(bus.Q),     32'(q_exp));
        chk({tag, ".valid"}, 32'(bus.valid), 32'(v_exp));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b_exp));
    endtask

    // Drive inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic d_v, input logic start_v, input logic ready_v);
        bus.d     = d_v;
        bus.start = start_v;
        bus.ready = ready_v;
        @(posedge c);
        #1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        c         = 1'b0;
        clk_en    = 1'b0;
        rn        = 1'b1;
        bus.d     = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b0;

        // 1: asynchronous reset with the clock stopped
        #3 rn = 1'b0;
        #2;
        chk_out("t1_async_rst", 4'b0000, 1'b0, 1'b0);
        clk_en = 1'b1;
        repeat (2) @(posedge c);
        #1 rn = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk_out("t1_idle_after_rel", 4'b0000, 1'b0, 1'b0);

        // 2: start then bits 1,0,1,1
        step(1'b0, 1'b1, 1'b0);
        chk_out("t2_start", 4'b0000, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t2_bit1", 4'b0001, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk_out("t2_bit2", 4'b0010, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t2_bit3", 4'b0101, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t2_full", 4'b1011, 1'b1, 1'b0);

        // 3: hold FULL with ready=0 while start and d toggle, then accept
        step(1'b0, 1'b1, 1'b0);
        chk_out("t3_hold1", 4'b1011, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_out("t3_hold2", 4'b1011, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_out("t3_hold3", 4'b1011, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk_out("t3_accept", 4'b1011, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t3_idle_d_ignored", 4'b1011, 1'b0, 1'b0);

        // 4: refill, then back-to-back accept+start with bits 0,1,1,0
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t4_refill", 4'b1011, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk_out("t4_b2b", 4'b1011, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk_out("t4_bit1", 4'b0110, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t4_bit2", 4'b1101, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t4_bit3", 4'b1011, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk_out("t4_full", 4'b0110, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_out("t4_accept", 4'b0110, 1'b0, 1'b0);

        // 5: reset mid-shift aborts the word; no restart without start
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("t5_mid", 4'b1011, 1'b0, 1'b1);
        rn = 1'b0;
        #2;
        chk_out("t5_rst", 4'b0000, 1'b0, 1'b0);
        @(posedge c);
        #1 rn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_out($sformatf("t5_idle%0d", i), 4'b0000, 1'b0, 1'b0);
        end

        // 6: ready in IDLE and start in SHIFT are ignored
        step(1'b1, 1'b0, 1'b1);
        chk_out("t6_ready_idle", 4'b0000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_out("t6_start", 4'b0000, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_out("t6_bit1", 4'b0001, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk_out("t6_bit2", 4'b0010, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk_out("t6_bit3", 4'b0100, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_out("t6_full", 4'b1001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_out("t6_accept", 4'b1001, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
